sha256_msg_padder: RTL and testbench

- Parametrised front end for the SHA-256 compression core.
- Accepts a message stream 1, 2 or 4 bytes per beat, applies FIPS 180-4 padding and the 64-bit big-endian bit-length field.
- Emits complete 512-bit blocks as 16 serial 32-bit words over a valid/ready handshake, with block-boundary and last-block flags.
- Replaces in-core byte padding, so the core only consumes pre-padded blocks.

---
 rtl/sha256_msg_padder.sv | 175 +++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// Purpose: SHA-256 front end. Takes 1/2/4-byte beats and emits padded 512-bit blocks as 16 big-endian words.
// Latency: word 0 of a data block is valid the cycle after the filling beat; final block 2 cycles after end of message.
// Backpressure: ready drops while a block drains; word_out and its flags hold while word_ready is low.
// Optional: define SHA_PAD_STATS_EN to add the block_count[15:0] output (blocks drained in the current message).
module sha256_msg_padder #(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [8*IN_BYTES-1:0]         data_in,
  input  logic                          data_valid,
  input  logic [$clog2(IN_BYTES+1)-1:0] data_bytes,
  input  logic                          end_of_file,
  output logic                          ready,
  output logic [31:0]                   word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          word_first,
  output logic                          block_last,
  output logic                          msg_done
`ifdef SHA_PAD_STATS_EN
  ,
  output logic [15:0]                   block_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_LEN, S_DRAIN} state_t;

  state_t           state;
  state_t           ret;        // where to go after a non-final block drains
  logic             final_blk;  // block currently draining is the last one of the message
  logic [7:0]       mem [64];   // block buffer, byte 0 is the first byte of the block
  logic [6:0]       pos;        // next free byte in the block, 0..64
  logic [3:0]       widx;       // word currently presented during drain
  logic [LEN_W-1:0] len_cnt;    // message length in bits, wraps modulo 2^LEN_W

  logic [6:0]       beat_bytes;
  logic [6:0]       pos_next;
  logic [LEN_W-1:0] len_add;
  logic [63:0]      len64;

  // Decode the current beat: final beats use data_bytes, all others are full.
  always_comb begin
    beat_bytes = end_of_file ? 7'(data_bytes) : 7'(IN_BYTES);
    pos_next   = pos + beat_bytes;
    len_add    = LEN_W'(beat_bytes) << 3;
    len64      = 64'(len_cnt);
  end

  // The word on the output is a direct read of the registered buffer; zero outside drain.
  assign word_out = word_valid ? {mem[{widx, 2'd0}], mem[{widx, 2'd1}],
                                  mem[{widx, 2'd2}], mem[{widx, 2'd3}]} : 32'h0;

  // Control FSM, buffer writes and registered handshake outputs.
  always_ff @(posedge clk) begin
    msg_done <= 1'b0;
    if (rst) begin
      state      <= S_IDLE;
      ret        <= S_FILL;
      final_blk  <= 1'b0;
      pos        <= 7'd0;
      widx       <= 4'd0;
      len_cnt    <= '0;
      ready      <= 1'b0;
      word_valid <= 1'b0;
      word_first <= 1'b0;
      block_last <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_FILL;
            ready   <= 1'b1;
            pos     <= 7'd0;
            len_cnt <= '0;
          end
        end

        S_FILL: begin
          if (data_valid) begin
            // Beats are aligned to IN_BYTES, so pos+j never leaves the block.
            for (int j = 0; j < IN_BYTES; j++) begin
              if (7'(j) < beat_bytes)
                mem[6'(pos + 7'(j))] <= data_in[8*(IN_BYTES-j)-1 -: 8];
            end
            pos     <= pos_next;
            len_cnt <= len_cnt + len_add;
            if (pos_next == 7'd64) begin
              // Block full: drain it, then either keep filling or pad in a fresh block.
              state      <= S_DRAIN;
              ret        <= end_of_file ? S_PAD : S_FILL;
              final_blk  <= 1'b0;
              ready      <= 1'b0;
              word_valid <= 1'b1;
              word_first <= 1'b1;
            end else if (end_of_file) begin
              state <= S_PAD;
              ready <= 1'b0;
            end
          end else if (end_of_file) begin
            // End marker without data closes the message after the last accepted beat.
            state <= S_PAD;
            ready <= 1'b0;
          end
        end

        S_PAD: begin
          mem[6'(pos)] <= 8'h80;
          if (pos <= 7'd55) begin
            for (int k = 0; k < 8; k++) mem[6'(56 + k)] <= len64[63-8*k -: 8];
            final_blk <= 1'b1;
          end else begin
            // No room for the length field: it goes into an extra all-zero block.
            final_blk <= 1'b0;
            ret       <= S_LEN;
          end
          state      <= S_DRAIN;
          word_valid <= 1'b1;
          word_first <= 1'b1;
        end

        S_LEN: begin
          for (int k = 0; k < 8; k++) mem[6'(56 + k)] <= len64[63-8*k -: 8];
          final_blk  <= 1'b1;
          state      <= S_DRAIN;
          word_valid <= 1'b1;
          word_first <= 1'b1;
        end

        S_DRAIN: begin
          if (word_ready) begin
            if (widx == 4'd15) begin
              for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
              pos        <= 7'd0;
              widx       <= 4'd0;
              word_valid <= 1'b0;
              word_first <= 1'b0;
              block_last <= 1'b0;
              if (final_blk) begin
                state    <= S_IDLE;
                msg_done <= 1'b1;
              end else begin
                state <= ret;
                ready <= (ret == S_FILL);
              end
            end else begin
              widx       <= widx + 4'd1;
              word_first <= 1'b0;
              block_last <= final_blk && (widx == 4'd14);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA_PAD_STATS_EN
  // Count drained blocks of the current message, saturating; restarts when a new message is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_count <= 16'h0000;
    end else if (state == S_IDLE && enable) begin
      block_count <= 16'h0000;
    end else if (state == S_DRAIN && word_ready && widx == 4'd15 && block_count != 16'hFFFF) begin
      block_count <= block_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: one IN_BYTES=1 and one IN_BYTES=4 instance, exercised one at a time.
// Expected words come from a byte-queue padding model; table vectors add fixed known-answer words.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  en, dv, eof, wr;
  logic [1:0]  rdy, wv, wf, bl, md;
  logic [31:0] wo [2];
  logic [7:0]  d1;
  logic [0:0]  db1;
  logic [31:0] d4;
  logic [2:0]  db4;
`ifdef SHA_PAD_STATS_EN
  logic [15:0] bc [2];
`endif

  sha256_msg_padder #(.IN_BYTES(1), .LEN_W(64)) u1 (
    .clk(clk), .rst(rst), .enable(en[0]), .data_in(d1), .data_valid(dv[0]),
    .data_bytes(db1), .end_of_file(eof[0]), .ready(rdy[0]), .word_out(wo[0]),
    .word_valid(wv[0]), .word_ready(wr[0]), .word_first(wf[0]), .block_last(bl[0]),
    .msg_done(md[0])
`ifdef SHA_PAD_STATS_EN
    , .block_count(bc[0])
`endif
  );

  sha256_msg_padder #(.IN_BYTES(4), .LEN_W(64)) u4 (
    .clk(clk), .rst(rst), .enable(en[1]), .data_in(d4), .data_valid(dv[1]),
    .data_bytes(db4), .end_of_file(eof[1]), .ready(rdy[1]), .word_out(wo[1]),
    .word_valid(wv[1]), .word_ready(wr[1]), .word_first(wf[1]), .block_last(bl[1]),
    .msg_done(md[1])
`ifdef SHA_PAD_STATS_EN
    , .block_count(bc[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  int          cur_sel;
  bit          cur_eofonly;
  bit          cur_gaps;
  logic [7:0]  cur_msg[$];
  logic [31:0] exp_words[$];
  logic [31:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %h expected %h", nm, cur_sel, act, exp);
    end
  endtask

  // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    p = cur_msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(cur_msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    exp_words.delete();
    for (int i = 0; i < p.size(); i += 4) exp_words.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endtask

  // Hold the current beat until the DUT takes it on a rising edge.
  task automatic wait_accept();
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = rdy[cur_sel];
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_msg();
    int n, nb, i, take;
    bit last;
    logic [31:0] w;
    n  = cur_msg.size();
    nb = (cur_sel == 1) ? 4 : 1;
    i  = 0;
    while (i < n) begin
      take = (n - i < nb) ? (n - i) : nb;
      last = (i + take == n);
      w = $urandom;
      for (int k = 0; k < take; k++) w[31-8*k -: 8] = cur_msg[i+k];
      if (cur_gaps && $urandom_range(0, 3) == 0) begin
        dv[cur_sel]  = 1'b0;
        eof[cur_sel] = 1'b0;
        @(posedge clk); #1;
      end
      dv[cur_sel]  = 1'b1;
      eof[cur_sel] = last && !cur_eofonly;
      if (cur_sel == 1) begin
        d4  = w;
        db4 = 3'(take);
      end else begin
        d1  = w[31:24];
        db1 = 1'b1;
      end
      wait_accept();
      i += take;
    end
    dv[cur_sel]  = 1'b0;
    eof[cur_sel] = 1'b0;
    if (n == 0 || cur_eofonly) begin
      eof[cur_sel] = 1'b1;
      wait_accept();
      eof[cur_sel] = 1'b0;
    end
  endtask

  task automatic collect_msg();
    int idx, t, nw;
    logic [31:0] held;
    bit was_stall;
    idx = 0;
    t = 0;
    nw = exp_words.size();
    was_stall = 1'b0;
    held = 32'h0;
    while (idx < nw && t < 5000) begin
      wr[cur_sel] = cur_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (was_stall && wv[cur_sel]) chk("hold_word", wo[cur_sel], held);
      was_stall = 1'b0;
      if (wv[cur_sel]) begin
        if (wr[cur_sel]) begin
          chk("word", wo[cur_sel], exp_words[idx]);
          chk("word_first", 32'(wf[cur_sel]), 32'(idx % 16 == 0));
          chk("block_last", 32'(bl[cur_sel]), 32'(idx == nw - 1));
          chk("done_early", 32'(md[cur_sel]), 32'd0);
          got.push_back(wo[cur_sel]);
          idx++;
        end else begin
          held = wo[cur_sel];
          was_stall = 1'b1;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    wr[cur_sel] = 1'b0;
    if (idx < nw) chk("drain_timeout", 32'(idx), 32'(nw));
    chk("msg_done", 32'(md[cur_sel]), 32'd1);
    chk("idle_ready", 32'(rdy[cur_sel]), 32'd0);
`ifdef SHA_PAD_STATS_EN
    chk("block_count", 32'(bc[cur_sel]), 32'(nw / 16));
`endif
    @(posedge clk); #1;
    chk("msg_done_pulse", 32'(md[cur_sel]), 32'd0);
  endtask

  task automatic run_msg();
    build_expected();
    got.delete();
    en[cur_sel] = 1'b1;
    @(posedge clk); #1;
    en[cur_sel] = 1'b0;
    fork
      drive_msg();
      collect_msg();
    join
  endtask

  task automatic fill_msg(input int len, input int kind);
    cur_msg.delete();
    for (int i = 0; i < len; i++) begin
      if (kind == 0)      cur_msg.push_back(8'(8'h61 + i));
      else if (kind == 1) cur_msg.push_back(8'(i + 1));
      else                cur_msg.push_back(8'($urandom));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ready"}, 32'(rdy[cur_sel]), 32'd0);
    chk({nm, "_word_valid"}, 32'(wv[cur_sel]), 32'd0);
    chk({nm, "_word_first"}, 32'(wf[cur_sel]), 32'd0);
    chk({nm, "_block_last"}, 32'(bl[cur_sel]), 32'd0);
    chk({nm, "_msg_done"}, 32'(md[cur_sel]), 32'd0);
    chk({nm, "_word_out"}, wo[cur_sel], 32'h0);
  endtask

  typedef struct {
    int          sel;
    int          len;
    int          kind;
    bit          eof_only;
    logic [31:0] w0_last;
    logic [31:0] w1_last;
    logic [31:0] w15_last;
    int          nblk;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   nb;
    int   t;

    vt[0] = '{0,  3, 0, 1'b0, 32'h61626380, 32'h00000000, 32'h00000018, 1};
    vt[1] = '{0,  0, 1, 1'b1, 32'h80000000, 32'h00000000, 32'h00000000, 1};
    vt[2] = '{0, 55, 1, 1'b0, 32'h01020304, 32'h05060708, 32'h000001B8, 1};
    vt[3] = '{0, 56, 1, 1'b1, 32'h00000000, 32'h00000000, 32'h000001C0, 2};
    vt[4] = '{0, 64, 1, 1'b0, 32'h80000000, 32'h00000000, 32'h00000200, 2};
    vt[5] = '{1,  5, 0, 1'b0, 32'h61626364, 32'h65800000, 32'h00000028, 1};

    rst = 1'b1;
    en = '0; dv = '0; eof = '0; wr = '0;
    d1 = '0; db1 = '0; d4 = '0; db4 = '0;
    cur_sel = 0; cur_eofonly = 1'b0; cur_gaps = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      check_reset_outputs("reset");
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      chk("idle_ready_no_enable", 32'(rdy[s]), 32'd0);
    end

    // Known-answer vectors.
    for (int v = 0; v < 6; v++) begin
      cur_sel     = vt[v].sel;
      cur_eofonly = vt[v].eof_only;
      cur_gaps    = 1'b0;
      fill_msg(vt[v].len, vt[v].kind);
      run_msg();
      chk("kat_word_count", 32'(got.size()), 32'(vt[v].nblk * 16));
      if (got.size() == vt[v].nblk * 16) begin
        chk("kat_w0", got[(vt[v].nblk - 1) * 16], vt[v].w0_last);
        chk("kat_w1", got[(vt[v].nblk - 1) * 16 + 1], vt[v].w1_last);
        chk("kat_w15", got[vt[v].nblk * 16 - 1], vt[v].w15_last);
      end
    end

    // Randomised messages with input gaps and output stalls.
    for (int r = 0; r < 40; r++) begin
      cur_sel  = $urandom_range(0, 1);
      nb       = (cur_sel == 1) ? 4 : 1;
      cur_gaps = 1'b1;
      fill_msg($urandom_range(0, 140), 2);
      cur_eofonly = (cur_msg.size() == 0) ||
                    ((cur_msg.size() % nb == 0) && ($urandom_range(0, 1) == 1));
      run_msg();
    end

    // "abcde" on the 4-byte instance: stall mid-drain, then reset during drain.
    cur_sel = 1;
    cur_eofonly = 1'b0;
    cur_gaps = 1'b0;
    fill_msg(5, 0);
    build_expected();
    en[1] = 1'b1;
    @(posedge clk); #1;
    en[1] = 1'b0;
    wr[1] = 1'b0;
    drive_msg();
    t = 0;
    while (!wv[1] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_wait_valid", 32'(wv[1]), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_w0", wo[1], 32'h61626364);
      chk("stall_w0_first", 32'(wf[1]), 32'd1);
      @(posedge clk); #1;
    end
    wr[1] = 1'b1;
    @(posedge clk); #1;
    wr[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_w1", wo[1], 32'h65800000);
      chk("stall_w1_first", 32'(wf[1]), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("drain_reset");
    wr[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_reset_no_done", 32'(md[1]), 32'd0);
      chk("post_reset_no_valid", 32'(wv[1]), 32'd0);
      @(posedge clk); #1;
    end
    wr[1] = 1'b0;

    // The instance must still work normally after the mid-drain reset.
    fill_msg(5, 0);
    run_msg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
